// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

    localparam int DIV_N  = 8;
    localparam int DIV_RW = DIV_N + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor and keep or restore the partial remainder.
module div_step
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic [N:0]   r,
    input  logic [N-1:0] q,
    input  logic [N-1:0] dv,
    output logic [N:0]   r_next,
    output logic [N-1:0] q_next
);

    logic [N:0]   trial;
    logic [N+1:0] diff;
    logic         unused_r_msb;

    // The partial remainder never exceeds the divisor, so its top bit is always 0.
    assign unused_r_msb = r[N];

    assign trial = {r[N-1:0], q[N-1]};
    assign diff  = {1'b0, trial} - {2'b00, dv};

    always_comb begin
        if (diff[N+1]) begin
            r_next = trial;
            q_next = {q[N-2:0], 1'b0};
        end else begin
            r_next = diff[N:0];
            q_next = {q[N-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional DIV_ZERO_DET_EN: a zero divisor skips the iterations and raises div_zero.
module div_seq
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inicio,
    input  logic [N-1:0] dividendo,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quoc,
    output logic [N:0]   rest,
    output logic         fim_div,
    output logic         ocupado,
    output logic         div_zero
);

    localparam int             CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

    div_state_t     state_reg, state_next;
    logic [N:0]     r_reg;
    logic [N-1:0]   q_reg;
    logic [N-1:0]   dv_reg;
    logic [CW-1:0]  cnt_reg;
    logic [N-1:0]   quoc_reg;
    logic [N:0]     rest_reg;
    logic [N:0]     r_step;
    logic [N-1:0]   q_step;
    logic           accept;
    logic           last_iter;

    div_step #(.N(N)) u_step (
        .r      (r_step_in_r()),
        .q      (q_reg),
        .dv     (dv_reg),
        .r_next (r_step),
        .q_next (q_step)
    );

    function automatic logic [N:0] r_step_in_r();
        return r_reg;
    endfunction

    assign last_iter = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        fim_div    = 1'b0;
        ocupado    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (inicio) begin
                    accept = 1'b1;
`ifdef DIV_ZERO_DET_EN
                    state_next = (divisor == '0) ? DONE : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: begin
                ocupado = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ocupado    = 1'b1;
                fim_div    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg    <= '0;
            q_reg    <= '0;
            dv_reg   <= '0;
            cnt_reg  <= '0;
            quoc_reg <= '0;
            rest_reg <= '0;
        end else if (accept) begin
            r_reg   <= '0;
            q_reg   <= dividendo;
            dv_reg  <= divisor;
            cnt_reg <= '0;
`ifdef DIV_ZERO_DET_EN
            if (divisor == '0) begin
                quoc_reg <= '1;
                rest_reg <= {1'b0, dividendo};
            end
`endif
        end else if (state_reg == CALC) begin
            r_reg   <= r_step;
            q_reg   <= q_step;
            cnt_reg <= cnt_reg + 1'b1;
            if (last_iter) begin
                quoc_reg <= q_step;
                rest_reg <= r_step;
            end
        end
    end

`ifdef DIV_ZERO_DET_EN
    logic dz_reg;

    // Flag follows each accepted request: set by a zero divisor, cleared by any other.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dz_reg <= 1'b0;
        end else if (accept) begin
            dz_reg <= (divisor == '0);
        end
    end

    assign div_zero = dz_reg;
`else
    assign div_zero = 1'b0;
`endif

    assign quoc = quoc_reg;
    assign rest = rest_reg;

endmodule
